// File: rtl/spi_sampler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_sampler_pkg                                            |
// | Description : Shared types and helpers for the SPI sampling master:      |
// |               FSM state encoding and the channel-index width function.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package spi_sampler_pkg;

    // Explicitly encoded 2-bit FSM state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Width of a channel index; never narrower than one bit so that a
    // single-channel build still has a legal port.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_clk_div                                                |
// | Description : SCLK generator. A half-period down-counter toggles sclk    |
// |               every CLK_DIV system clocks while enabled; sclk parks high |
// |               and the counter clears whenever the enable is low.         |
// | Ports       : clk, rst_l      - system clock, async active-low reset     |
// |               i_en            - run the divider                          |
// |               o_sclk          - registered SPI clock (idle high)         |
// |               o_rise          - strobe on the edge that drives sclk high |
// |               o_phase_end     - current half-period ends on this edge    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_l,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_phase_end
);

    localparam int                 c_CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sclk;

    // A counter value of zero on an enabled edge means "toggle now", so the
    // very first enabled edge produces the initial falling edge of sclk.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_cnt  <= '0;
            r_sclk <= 1'b1;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b1;
        end else if (r_cnt == '0) begin
            r_cnt  <= c_CNT_MAX;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    // Phase-end does not depend on the enable, which keeps the top-level
    // next-state logic (that produces the enable) free of loops.
    assign o_phase_end = (r_cnt == '0);
    assign o_rise      = i_en && o_phase_end && !r_sclk;
    assign o_sclk      = r_sclk;

endmodule
`default_nettype wire

// File: rtl/spi_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_sampler                                                |
// | Description : SPI sampling master. Reads FRAME_BITS-bit frames (MSB      |
// |               first) from NUM_CH slaves sharing SCLK/SDO, either on a    |
// |               manual start or from a free-running refresh timer with a   |
// |               round-robin channel pointer. Frames are presented with     |
// |               their channel through a valid/ack handshake; a frame that  |
// |               lands on an unconsumed one raises the sticky overrun flag. |
// | Ports       : clk, rst_l      - system clock, async active-low reset     |
// |               sdo             - serial data from selected slave          |
// |               auto_en         - enable timer-driven acquisition          |
// |               start, ch_sel   - manual one-cycle request and channel     |
// |               data_ack        - consumer accepts data_out                |
// |               sclk, cs_n      - SPI clock (idle high), chip selects      |
// |               busy            - conversion in progress                   |
// |               data_valid, data_out, data_ch - frame handshake            |
// |               overrun         - sticky, cleared only by reset            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module spi_sampler
    import spi_sampler_pkg::*;
#(
    parameter  int CLK_DIV        = 2,
    parameter  int FRAME_BITS     = 16,
    parameter  int NUM_CH         = 1,
    parameter  int REFRESH_CYCLES = 40_000,
    localparam int CH_W           = ch_width(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  sdo,
    input  logic                  auto_en,
    input  logic                  start,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic                  data_ack,
    output logic                  sclk,
    output logic [NUM_CH-1:0]     cs_n,
    output logic                  busy,
    output logic                  data_valid,
    output logic [FRAME_BITS-1:0] data_out,
    output logic [CH_W-1:0]       data_ch,
    output logic                  overrun
);

    localparam int                  c_WAIT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(CLK_DIV - 1);
    localparam int                  c_BIT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST = c_BIT_W'(FRAME_BITS);
    localparam int                  c_TMR_W    = $clog2(REFRESH_CYCLES);
    localparam logic [c_TMR_W-1:0]  c_TMR_MAX  = c_TMR_W'(REFRESH_CYCLES - 1);
    localparam logic [CH_W:0]       c_NUM_CH   = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W-1:0]     c_LAST_CH  = CH_W'(NUM_CH - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [c_WAIT_W-1:0]     r_wait;
    logic [c_BIT_W-1:0]      r_bit_cnt;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [CH_W-1:0]         r_ch;
    logic [NUM_CH-1:0]       r_cs_n;
    logic                    r_busy;
    logic                    r_data_valid;
    logic [FRAME_BITS-1:0]   r_data_out;
    logic [CH_W-1:0]         r_data_ch;
    logic                    r_overrun;
    logic [c_TMR_W-1:0]      r_timer;
    logic                    r_tick_pend;
    logic [CH_W-1:0]         r_auto_ptr;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    state_t                  w_state_next;
    logic                    w_in_idle;
    logic                    w_start_ok;
    logic                    w_accept;
    logic                    w_serve_tick;
    logic [CH_W-1:0]         w_req_ch;
    logic [CH_W-1:0]         w_ch_next;
    logic [NUM_CH-1:0]       w_ch_hit;
    logic                    w_frame_done;
    logic                    w_sclk;
    logic                    w_rise;
    logic                    w_phase_end;
    logic                    w_div_en;
    logic [NUM_CH-1:0]       w_cs_n_next;
    logic                    w_busy_next;

    // ------------------------------------------------------------------
    // Request arbitration: an in-range manual start beats a pending tick,
    // and the tick stays pending for the next idle cycle.
    // ------------------------------------------------------------------
    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_start_ok   = start && ({1'b0, ch_sel} < c_NUM_CH);
    assign w_accept     = w_in_idle && (w_start_ok || r_tick_pend);
    assign w_serve_tick = w_in_idle && !w_start_ok && r_tick_pend;
    assign w_req_ch     = w_start_ok ? ch_sel : r_auto_ptr;
    assign w_ch_next    = w_accept ? w_req_ch : r_ch;

    // The frame is complete once every bit has been sampled and the final
    // high phase has run its full length.
    assign w_frame_done = (r_state == ST_SHIFT) && (r_bit_cnt == c_BIT_LAST)
                          && w_phase_end && w_sclk;

    // Driving the divider from the next state lets the first sclk fall land
    // on the same edge that enters SHIFT, and lets the divider park sclk high
    // on the edge that leaves it.
    assign w_div_en = (w_state_next == ST_SHIFT);

    spi_clk_div #(
        .CLK_DIV     (CLK_DIV)
    ) u_clk_div (
        .clk         (clk),
        .rst_l       (rst_l),
        .i_en        (w_div_en),
        .o_sclk      (w_sclk),
        .o_rise      (w_rise),
        .o_phase_end (w_phase_end)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)      w_state_next = ST_SETUP;
            ST_SETUP: if (r_wait == '0)  w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_frame_done)  w_state_next = ST_HOLD;
            ST_HOLD:  if (r_wait == '0)  w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered bus outputs)
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cs_dec
        assign w_ch_hit[gi] = (w_ch_next == CH_W'(gi));
    end

    always_comb begin
        w_cs_n_next = '1;
        w_busy_next = 1'b0;
        case (w_state_next)
            ST_SETUP, ST_SHIFT: begin
                w_cs_n_next = ~w_ch_hit;
                w_busy_next = 1'b1;
            end
            ST_HOLD: begin
                w_busy_next = 1'b1;
            end
            default: begin
                w_cs_n_next = '1;
                w_busy_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_cs_n <= '1;
            r_busy <= 1'b0;
        end else begin
            r_cs_n <= w_cs_n_next;
            r_busy <= w_busy_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: phase timer, bit counter, shift register, latched channel
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wait    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ch      <= '0;
        end else begin
            // SETUP and HOLD each last CLK_DIV cycles from entry.
            if (w_state_next != r_state) begin
                r_wait <= c_WAIT_MAX;
            end else if (r_wait != '0) begin
                r_wait <= r_wait - 1'b1;
            end

            if (w_accept) begin
                r_ch      <= w_req_ch;
                r_bit_cnt <= '0;
            end else if (w_rise) begin
                r_shift   <= {r_shift[FRAME_BITS-2:0], sdo};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output handshake. A completing frame takes priority over an ack on
    // the same edge: the new frame is loaded, valid stays high, and the ack
    // counts as consuming the old frame so no overrun is flagged.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
            r_data_ch    <= '0;
            r_overrun    <= 1'b0;
        end else if (w_frame_done) begin
            r_data_valid <= 1'b1;
            r_data_out   <= r_shift;
            r_data_ch    <= r_ch;
            if (r_data_valid && !data_ack) begin
                r_overrun <= 1'b1;
            end
        end else if (data_ack) begin
            r_data_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Refresh timer, one-deep pending tick and round-robin pointer.
    // A wrap on the same edge a tick is served re-arms the pending flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_timer     <= '0;
            r_tick_pend <= 1'b0;
        end else if (!auto_en) begin
            r_timer     <= '0;
            r_tick_pend <= 1'b0;
        end else if (r_timer == c_TMR_MAX) begin
            r_timer     <= '0;
            r_tick_pend <= 1'b1;
        end else begin
            r_timer <= r_timer + 1'b1;
            if (w_serve_tick) begin
                r_tick_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_auto_ptr <= '0;
        end else if (w_serve_tick) begin
            r_auto_ptr <= (r_auto_ptr == c_LAST_CH) ? '0 : r_auto_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign sclk       = w_sclk;
    assign cs_n       = r_cs_n;
    assign busy       = r_busy;
    assign data_valid = r_data_valid;
    assign data_out   = r_data_out;
    assign data_ch    = r_data_ch;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
